// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package ifetch_pkg;

    typedef enum logic [1:0] {
        BOOT      = 2'd0,
        REQ       = 2'd1,
        WAIT      = 2'd2,
        WAIT_DROP = 2'd3
    } ifetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/ifetch_slot.sv
// One-entry decode slot: holds the fetched instruction, its PC and PC+4,
// with load, drain (valid/ready) and flush.
module ifetch_slot
    import ifetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     flush,
    input  logic                     ready,
    input  logic [DATA_WIDTH-1:0]    load_instr,
    input  logic [ADDRESS_WIDTH-1:0] load_pc,
    output logic                     valid,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4
);

    logic                     valid_q, valid_d;
    logic [DATA_WIDTH-1:0]    instr_q, instr_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [ADDRESS_WIDTH-1:0] pc_plus4_q, pc_plus4_d;

    // Flush wins over load, and a load in the same cycle as a drain keeps valid set.
    always_comb begin
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d    = 1'b1;
            instr_d    = load_instr;
            pc_d       = load_pc;
            pc_plus4_d = load_pc + ADDRESS_WIDTH'(4);
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            instr_q    <= DATA_WIDTH'(NOP_INSTR);
            pc_q       <= '0;
            pc_plus4_q <= ADDRESS_WIDTH'(4);
        end else begin
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign valid    = valid_q;
    assign instr    = instr_q;
    assign pc       = pc_q;
    assign pc_plus4 = pc_plus4_q;

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch-stage controller: owns the fetch PC, runs the single-outstanding
// req/gnt/rvalid imem protocol and handles redirects from execute.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [DATA_WIDTH-1:0]    id_instr,
    output logic [ADDRESS_WIDTH-1:0] id_pc,
    output logic [ADDRESS_WIDTH-1:0] id_pc_plus4
);

    ifetch_state_t            state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                     granted;
    logic                     slot_load;

    // Only request when the slot is guaranteed free by the time the response lands.
    assign imem_req  = (state_q == REQ) && (!id_valid || id_ready);
    assign imem_addr = fetch_pc_q;
    assign granted   = imem_req && imem_gnt;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        slot_load  = 1'b0;
        if (redirect_valid) begin
            // An ungranted request may change address; a granted one must be drained.
            fetch_pc_d = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
            case (state_q)
                BOOT:            state_d = REQ;
                REQ:             state_d = granted ? WAIT_DROP : REQ;
                WAIT, WAIT_DROP: state_d = imem_rvalid ? REQ : WAIT_DROP;
                default:         state_d = BOOT;
            endcase
        end else begin
            case (state_q)
                BOOT: state_d = REQ;
                REQ: begin
                    if (granted) state_d = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        slot_load  = 1'b1;
                        fetch_pc_d = fetch_pc_q + ADDRESS_WIDTH'(4);
                        state_d    = REQ;
                    end
                end
                WAIT_DROP: begin
                    if (imem_rvalid) state_d = REQ;
                end
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    ifetch_slot #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (slot_load),
        .flush      (redirect_valid),
        .ready      (id_ready),
        .load_instr (imem_rdata),
        .load_pc    (fetch_pc_q),
        .valid      (id_valid),
        .instr      (id_instr),
        .pc         (id_pc),
        .pc_plus4   (id_pc_plus4)
    );

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller for the pipelined core's fetch stage. It owns the fetch PC and issues word requests to instruction memory over a req/gnt/rvalid protocol with one request outstanding. It holds each returned instruction in a one-entry output slot and hands it to decode with a valid/ready handshake. Branch/jump redirects from execute retarget the PC, flush the slot and discard any in-flight response.

## Interface
- ADDRESS_WIDTH, 32, width of the PC and imem address
- DATA_WIDTH, 32, instruction width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  request valid
- imem_addr  out  ADDRESS_WIDTH  word address; sampled by memory only in the cycle `imem_gnt`=1
- imem_gnt  in  1  request accepted this cycle; ignored unless `imem_req`=1
- imem_rvalid  in  1  response valid; at least 1 cycle after the grant, exactly once per grant
- imem_rdata  in  DATA_WIDTH  instruction data, valid with `imem_rvalid`
- redirect_valid  in  1  single-cycle redirect from execute
- redirect_pc  in  ADDRESS_WIDTH  redirect target
- id_valid  out  1  decode slot holds an instruction
- id_ready  in  1  decode accepts the slot this cycle
- id_instr  out  DATA_WIDTH  slot instruction
- id_pc  out  ADDRESS_WIDTH  PC of the slot instruction
- id_pc_plus4  out  ADDRESS_WIDTH  `id_pc`+4

## Operation
- States:
  - BOOT: one cycle after reset release.
  - REQ: a request is pending.
  - WAIT: a granted request is awaiting its response.
  - WAIT_DROP: a granted request's response must be discarded.
- Reset values: state=BOOT, `fetch_pc`=RESET_PC, `imem_req`=0, `imem_addr`=RESET_PC, `id_valid`=0, `id_instr`=32'h0000_0013 (NOP), `id_pc`=0, `id_pc_plus4`=4.
- `imem_addr` = `fetch_pc` register, always.
- BOOT -> REQ unconditionally.
- REQ: `imem_req` = (!`id_valid` || `id_ready`), combinational. On `imem_req`&&`imem_gnt` -> WAIT. This guarantees the slot is free when the response returns.
- WAIT, on `imem_rvalid`:
  - `id_instr`<=`imem_rdata`, `id_pc`<=`fetch_pc`, `id_pc_plus4`<=`fetch_pc`+4, `id_valid`<=1.
  - `fetch_pc`<=`fetch_pc`+4.
  - -> REQ.
- WAIT_DROP, on `imem_rvalid`: data dropped, no slot or PC update; -> REQ.
- Slot: `id_valid` clears on `id_valid`&&`id_ready` unless loaded the same cycle. Load and drain in the same cycle: new contents, `id_valid` stays 1.
- Redirect (`redirect_valid`=1) has priority over everything:
  - `fetch_pc`<=`redirect_pc` with bits [1:0] forced to 0.
  - `id_valid`<=0; a same-cycle `id_ready` handshake is void.
  - From REQ without grant -> REQ; the next cycle presents the new address, which is legal because it was never granted.
  - From REQ with grant, or from WAIT or WAIT_DROP without `imem_rvalid` -> WAIT_DROP.
  - From WAIT or WAIT_DROP with `imem_rvalid` -> REQ; the response is dropped.
  - In BOOT -> REQ at the redirect target.
- PC arithmetic wraps modulo 2^ADDRESS_WIDTH. No misalignment trap.
- Reset mid-transaction returns every state to reset values. The imem interface is reset by the same `rst`, so no late response arrives.

## Timing
- Reset release at edge E0: BOOT in cycle 0; `imem_req`=1 with `imem_addr`=RESET_PC from cycle 1.
- `id_valid` rises the edge after `imem_rvalid`.
- Minimum fetch latency is 3 cycles from request to slot: REQ+gnt, then WAIT+rvalid, then slot valid.
- Peak throughput is 1 instruction per 2 cycles: at most one request outstanding.
- Redirect at cycle N: `imem_addr`=target from cycle N+1; `id_valid`=0 in cycle N+1.

## Structure
- Shared package `ifetch_pkg`: `ifetch_state_t` enum (BOOT, REQ, WAIT, WAIT_DROP) and `NOP_INSTR` = 32'h0000_0013.
- One sub-module, `ifetch_slot`: the output register with load/drain/flush and valid logic. The FSM and `fetch_pc` stay in `ifetch_ctrl`.

## Test plan
- Reset release, `id_ready`=1, memory grants immediately with 1-cycle latency -> requests at 0x0, 0x4, 0x8 on alternate cycles; `id_pc` sequence 0x0, 0x4, 0x8; instructions match memory.
- `id_ready`=0 for 10 cycles after the first instruction -> `imem_req`=0 throughout; slot holds PC 0x0; fetch at 0x4 is requested in the cycle `id_ready` rises.
- Grant delayed 3 cycles -> `imem_req` and `imem_addr` stable until the grant; exactly one response captured.
- `redirect_valid` with `redirect_pc`=0x100 while in WAIT (response lands 2 cycles later) -> that response dropped; next request at 0x100; first `id_pc` after the redirect is 0x100.
- Redirect to 0x203 in the same cycle as `imem_rvalid` and `id_valid`&&`id_ready` -> response dropped, slot cleared, next `imem_addr`=0x200.
- `rst` asserted in WAIT -> next cycle all outputs at reset values; after release, fetch restarts at RESET_PC.
